// File: rtl/pipeline_ks_addsub.sv
// ---------------------------------------------------------------------------
// pipeline_ks_addsub
//
// Pipelined Kogge-Stone adder/subtractor with a generic width and selectable
// register placement inside the prefix network.
//
//   sub = 0 : {cout, sum} = a + b + cin
//   sub = 1 : {cout, sum} = a + ~b + !cin   (a - b - cin, cout = 1 -> no borrow)
//
// Parameters
//   WIDTH     operand / sum width, any value >= 2
//   PIPE_MASK bit k set -> register bank after prefix level k
//             (bits at or above the number of prefix levels are ignored)
//   TAG_W     width of the sideband tag that travels with each operation
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand beat handshake
//   a, b, cin, sub, tag operand beat
//   out_valid,out_ready result handshake
//   sum, cout, ovf,     result, raw carry out of the MSB, signed overflow,
//   zero, out_tag       sum == 0, tag of this result
//
// Latency from an accepted beat to out_valid is popcount(used PIPE_MASK) + 1.
// ---------------------------------------------------------------------------
module pipeline_ks_addsub #(
    parameter int          WIDTH     = 64,
    parameter logic [31:0] PIPE_MASK = 32'b001010,
    parameter int          TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = $clog2(WIDTH);
    // Prefix vectors carry one extra position at index 0 that stands for
    // bit -1: its generate is the effective carry-in, its propagate is 0.
    // Position j (j >= 1) is bit j-1 of the operands.
    localparam int N = WIDTH + 1;

    // One pipeline bank. gg/pg are the group generate/propagate after the
    // level that feeds the bank. Once a position's group reaches index 0 its
    // pg is the constant 0 (pg[0] = 0 is ANDed in), so those flops fold away
    // and only the still-unresolved group terms survive in each bank.
    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] p;
        logic [N-1:0]     gg;
        logic [N-1:0]     pg;
    } stage_t;

    stage_t bank_d [LEVELS];
    stage_t bank_q [LEVELS];

    logic             stall;
    logic             en;
    logic             accept;
    logic             valid_d;
    logic [TAG_W-1:0] tag_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    // Handshake: a beat moves on a rising edge when valid and ready are both
    // high on that side. The whole pipe shares one enable; it stops only
    // when a finished result is waiting for out_ready, so bubbles travel as
    // valid = 0 and are never squeezed out.
    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;
    assign accept   = in_valid & in_ready;

    always_comb begin : prefix_net
        stage_t           cur;
        stage_t           nxt;
        logic [WIDTH-1:0] b_eff;
        logic             cin_eff;
        nxt     = '0;
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? ~cin : cin;
        cur.v   = accept;
        cur.tag = tag;
        cur.p   = a ^ b_eff;
        cur.gg  = {a & b_eff, cin_eff};
        cur.pg  = {a ^ b_eff, 1'b0};
        for (int k = 0; k < LEVELS; k++) begin
            nxt = cur;
            // Positions below the span have no partner: identity (g=0, p=1),
            // so they simply pass through unchanged.
            for (int j = (1 << k); j < N; j++) begin
                nxt.gg[j] = cur.gg[j] | (cur.pg[j] & cur.gg[j - (1 << k)]);
                nxt.pg[j] = cur.pg[j] & cur.pg[j - (1 << k)];
            end
            bank_d[k] = nxt;
            cur = PIPE_MASK[k] ? bank_q[k] : nxt;
        end
        valid_d = cur.v;
        tag_d   = cur.tag;
        // gg[i] is the carry into bit i (gg[0] is the effective carry-in).
        sum_d   = cur.p ^ cur.gg[WIDTH-1:0];
        // With WIDTH a power of two the top group stops at bit 0 and still
        // needs the carry-in folded in; otherwise pg[WIDTH] is already 0.
        cout_d  = cur.gg[WIDTH] | (cur.pg[WIDTH] & cur.gg[0]);
        ovf_d   = cout_d ^ cur.gg[WIDTH-1];
        zero_d  = ~|sum_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LEVELS; k++) begin
                bank_q[k] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_tag   <= '0;
        end else if (en) begin
            for (int k = 0; k < LEVELS; k++) begin
                if (PIPE_MASK[k]) begin
                    bank_q[k] <= bank_d[k];
                end
            end
            out_valid <= valid_d;
            // Bubbles leave the last result on the outputs.
            if (valid_d) begin
                sum     <= sum_d;
                cout    <= cout_d;
                ovf     <= ovf_d;
                zero    <= zero_d;
                out_tag <= tag_d;
            end
        end
    end

endmodule
